// File: rtl/cmd_pkg.sv
// Command opcodes and decoder state encodings, shared by the receive-side decoder
// and the response/transmit side.
package cmd_pkg;

    localparam logic [7:0] CMD_REG_WR  = 8'hAA;
    localparam logic [7:0] CMD_REG_RD  = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_ALU_A   = 3'd4,
        ST_ALU_B   = 3'd5,
        ST_ALU_FUN = 3'd6
    } cmd_state_e;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter: flags the cycle in which a stalled frame has used up its
// allowance of TIMEOUT_CYC idle cycles.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int               CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // A clear in the same cycle suppresses expiry, so an arriving byte always wins.
    assign expired = en && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || expired) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles synchronized bytes into register/ALU command frames and issues
// one-cycle requests; aborts frames that stall longer than TIMEOUT_CYC cycles.
module cmd_frame_decoder
    import cmd_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FUN_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  alu_en,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [FUN_WIDTH-1:0]  alu_fun,
    output logic                  busy,
    output logic                  frame_err
);

    cmd_state_e state;
    logic       tmo_expired;
    logic       in_idle;

    assign in_idle = (state == ST_IDLE);
    assign busy    = !in_idle;

    frame_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || in_idle),
        .en      (!in_idle),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            alu_en      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_fun     <= '0;
            frame_err   <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            alu_en    <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        // Opcodes are only recognised here; mid-frame bytes are plain data.
                        case (rx_data)
                            DATA_WIDTH'(CMD_REG_WR):  state <= ST_WR_ADDR;
                            DATA_WIDTH'(CMD_REG_RD):  state <= ST_RD_ADDR;
                            DATA_WIDTH'(CMD_ALU_OP):  state <= ST_ALU_A;
                            DATA_WIDTH'(CMD_ALU_NOP): state <= ST_ALU_FUN;
                            default:                  frame_err <= 1'b1;
                        endcase
                    end
                    ST_WR_ADDR: begin
                        reg_addr <= rx_data[ADDR_WIDTH-1:0];
                        state    <= ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        reg_wr_data <= rx_data;
                        reg_wr_en   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    ST_RD_ADDR: begin
                        reg_addr  <= rx_data[ADDR_WIDTH-1:0];
                        reg_rd_en <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    ST_ALU_A: begin
                        alu_a <= rx_data;
                        state <= ST_ALU_B;
                    end
                    ST_ALU_B: begin
                        alu_b <= rx_data;
                        state <= ST_ALU_FUN;
                    end
                    ST_ALU_FUN: begin
                        alu_fun <= rx_data[FUN_WIDTH-1:0];
                        alu_en  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (tmo_expired) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed-vector bench for cmd_frame_decoder with a short timeout.
module tb_cmd_frame_decoder;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int FW  = 4;
    localparam int TMO = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data;
    logic          alu_en;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [FW-1:0] alu_fun;
    logic          busy;
    logic          frame_err;

    int n_vec = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_rd  = 0;
    int n_alu = 0;
    int n_err = 0;
    int n_ovl = 0;

    cmd_frame_decoder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .FUN_WIDTH   (FW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .alu_en      (alu_en),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_fun     (alu_fun),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies, sampled on the inactive edge.
    always @(negedge clk) begin
        if (reg_wr_en) n_wr++;
        if (reg_rd_en) n_rd++;
        if (alu_en)    n_alu++;
        if (frame_err) n_err++;
        if (int'(reg_wr_en) + int'(reg_rd_en) + int'(alu_en) > 1) n_ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe one byte for one cycle; returns on the negedge after it is consumed.
    task automatic send(input logic [DW-1:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", {reg_wr_en, reg_rd_en, alu_en, frame_err, reg_addr, alu_fun}, 0);
        chk("rst_data", {reg_wr_data, alu_a, alu_b}, 0);
        rst = 1'b1;
        idle(2);

        // 1: register write with 4-cycle gaps
        send(8'hAA);
        chk("t1_busy_op", 32'(busy), 1);
        idle(4);
        chk("t1_busy_gap", 32'(busy), 1);
        send(8'h05);
        idle(4);
        chk("t1_busy_gap2", 32'(busy), 1);
        chk("t1_no_wr_yet", 32'(reg_wr_en), 0);
        send(8'h3C);
        chk("t1_wr_en", 32'(reg_wr_en), 1);
        chk("t1_addr", 32'(reg_addr), 32'h5);
        chk("t1_data", 32'(reg_wr_data), 32'h3C);
        chk("t1_busy_end", 32'(busy), 0);
        idle(1);
        chk("t1_wr_pulse", 32'(reg_wr_en), 0);
        idle(1);
        chk("t1_n_wr", 32'(n_wr), 1);

        // 2: ALU op with operands, then operand reuse
        send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
        chk("t2_alu_en", 32'(alu_en), 1);
        chk("t2_ab", {alu_a, alu_b}, 32'h1234);
        chk("t2_fun", 32'(alu_fun), 32'h1);
        send(8'hDD); send(8'h02);
        chk("t2_nop_en", 32'(alu_en), 1);
        chk("t2_nop_ab", {alu_a, alu_b}, 32'h1234);
        chk("t2_nop_fun", 32'(alu_fun), 32'h2);
        idle(2);
        chk("t2_n_alu", 32'(n_alu), 2);

        // 3: unknown opcode, then register read with upper address bits set
        send(8'h7E);
        chk("t3_err", 32'(frame_err), 1);
        chk("t3_busy", 32'(busy), 0);
        idle(1);
        chk("t3_err_pulse", 32'(frame_err), 0);
        send(8'hBB); send(8'hF3);
        chk("t3_rd_en", 32'(reg_rd_en), 1);
        chk("t3_addr", 32'(reg_addr), 32'h3);
        idle(2);
        chk("t3_counts", {8'(n_err), 8'(n_rd), 8'(n_wr), 8'(n_alu)}, 32'h01010102);

        // 4a: stalled frame times out after TMO idle cycles
        send(8'hAA);
        idle(TMO - 1);
        chk("t4_busy_pre", 32'(busy), 1);
        chk("t4_err_pre", 32'(frame_err), 0);
        idle(1);
        chk("t4_tmo_err", 32'(frame_err), 1);
        chk("t4_tmo_busy", 32'(busy), 0);
        idle(2);
        chk("t4_tmo_counts", {8'(n_err), 8'(n_wr)}, 32'h0201);

        // 4b: byte landing on the expiry cycle is accepted
        send(8'hAA);
        idle(TMO - 2);
        send(8'h07);
        chk("t4_edge_busy", 32'(busy), 1);
        chk("t4_edge_err", 32'(frame_err), 0);
        chk("t4_edge_addr", 32'(reg_addr), 32'h7);
        send(8'h99);
        chk("t4_edge_wr", 32'(reg_wr_en), 1);
        chk("t4_edge_data", 32'(reg_wr_data), 32'h99);
        idle(2);
        chk("t4_edge_counts", {8'(n_err), 8'(n_wr)}, 32'h0202);

        // 5: reset mid-frame clears operands; DD then uses zeros
        send(8'hCC); send(8'h11);
        chk("t5_a_pre", 32'(alu_a), 32'h11);
        rst = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_regs", {alu_a, alu_b, reg_wr_data, reg_addr, alu_fun}, 0);
        idle(2);
        rst = 1'b1;
        idle(1);
        send(8'hDD); send(8'h04);
        chk("t5_alu_en", 32'(alu_en), 1);
        chk("t5_ab", {alu_a, alu_b}, 0);
        chk("t5_fun", 32'(alu_fun), 32'h4);
        idle(2);
        chk("t5_n_alu", 32'(n_alu), 3);

        // 6: opcode-valued bytes mid-frame are data
        send(8'hAA); send(8'hAA); send(8'hBB);
        chk("t6_wr_en", 32'(reg_wr_en), 1);
        chk("t6_addr", 32'(reg_addr), 32'hA);
        chk("t6_data", 32'(reg_wr_data), 32'hBB);
        chk("t6_busy", 32'(busy), 0);
        idle(2);
        chk("t6_counts", {8'(n_wr), 8'(n_rd), 8'(n_err)}, 32'h030102);
        chk("no_overlap", 32'(n_ovl), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
